apb_master_bridge: RTL and testbench

APB requester (initiator) that turns single-beat local read/write commands into APB protocol transfers toward the interrupt controller's APB slave port and other peripheral slaves. The block generates per-byte odd-parity check bits for address, write data and strobe, and checks PRDATACHK on reads. It supports slave wait states through PREADY, bounds them with a timeout, and returns one response per command over a valid/ready handshake. It sits between the CPU/test bus fabric and the peripheral APB segment.

---
 rtl/apb_master_bridge.sv | 198 +++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: turns single-beat local commands into APB transfers with per-byte odd parity,
// bounded wait states, and one response per command over a valid/ready handshake.
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int PARITY_WIDTH   = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   // local command channel
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [STRB_WIDTH-1:0]   cmd_strb,
   // local response channel
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_slverr,
   output logic                    rsp_parity_err,
   output logic                    rsp_timeout,
   // APB requester side
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [STRB_WIDTH-1:0]   PSTRB,
   output logic [PARITY_WIDTH-1:0] PADDRCHK,
   output logic [PARITY_WIDTH-1:0] PWDATACHK,
   output logic                    PSTRBCHK,
   input  logic                    PREADY,
   input  logic                    PSLVERR,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic [PARITY_WIDTH-1:0] PRDATACHK
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                  state_reg;
   logic                    cmd_ready_reg;
   logic                    psel_reg;
   logic                    penable_reg;
   logic                    pwrite_reg;
   logic [ADDR_WIDTH-1:0]   paddr_reg;
   logic [DATA_WIDTH-1:0]   pwdata_reg;
   logic [STRB_WIDTH-1:0]   pstrb_reg;
   logic [PARITY_WIDTH-1:0] paddrchk_reg;
   logic [PARITY_WIDTH-1:0] pwdatachk_reg;
   logic                    pstrbchk_reg;
   logic [CNT_W-1:0]        wait_cnt_reg;
   logic                    rsp_valid_reg;
   logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
   logic                    rsp_slverr_reg;
   logic                    rsp_parity_err_reg;
   logic                    rsp_timeout_reg;

   logic [PARITY_WIDTH-1:0] addr_chk_next;
   logic [PARITY_WIDTH-1:0] wdata_chk_next;
   logic [PARITY_WIDTH-1:0] rdata_chk_exp;
   logic [STRB_WIDTH-1:0]   strb_next;

   // Odd parity per byte: check bit makes the byte plus check bit carry an odd number of ones.
   genvar gi;
   generate
      for (gi = 0; gi < PARITY_WIDTH; gi++) begin : g_parity
         assign addr_chk_next[gi]  = ~^cmd_addr[gi*8 +: 8];
         assign wdata_chk_next[gi] = ~^cmd_wdata[gi*8 +: 8];
         assign rdata_chk_exp[gi]  = ~^PRDATA[gi*8 +: 8];
      end
   endgenerate

   assign strb_next = cmd_write ? cmd_strb : '0;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_reg          <= S_IDLE;
         cmd_ready_reg      <= 1'b1;
         psel_reg           <= 1'b0;
         penable_reg        <= 1'b0;
         pwrite_reg         <= 1'b0;
         paddr_reg          <= '0;
         pwdata_reg         <= '0;
         pstrb_reg          <= '0;
         paddrchk_reg       <= '1;
         pwdatachk_reg      <= '1;
         pstrbchk_reg       <= 1'b1;
         wait_cnt_reg       <= '0;
         rsp_valid_reg      <= 1'b0;
         rsp_rdata_reg      <= '0;
         rsp_slverr_reg     <= 1'b0;
         rsp_parity_err_reg <= 1'b0;
         rsp_timeout_reg    <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid) begin
                  pwrite_reg    <= cmd_write;
                  paddr_reg     <= cmd_addr;
                  pwdata_reg    <= cmd_wdata;
                  pstrb_reg     <= strb_next;
                  paddrchk_reg  <= addr_chk_next;
                  pwdatachk_reg <= wdata_chk_next;
                  pstrbchk_reg  <= ~^strb_next;
                  psel_reg      <= 1'b1;
                  cmd_ready_reg <= 1'b0;
                  state_reg     <= S_SETUP;
               end
            end

            S_SETUP: begin
               penable_reg  <= 1'b1;
               wait_cnt_reg <= CNT_W'(1);
               state_reg    <= S_ACCESS;
            end

            S_ACCESS: begin
               // PREADY wins over the timeout when both land in the same cycle.
               if (PREADY) begin
                  psel_reg        <= 1'b0;
                  penable_reg     <= 1'b0;
                  rsp_valid_reg   <= 1'b1;
                  rsp_slverr_reg  <= PSLVERR;
                  rsp_timeout_reg <= 1'b0;
                  if (pwrite_reg) begin
                     rsp_rdata_reg      <= '0;
                     rsp_parity_err_reg <= 1'b0;
                  end else begin
                     rsp_rdata_reg      <= PRDATA;
                     rsp_parity_err_reg <= (PRDATACHK != rdata_chk_exp);
                  end
                  state_reg <= S_RESP;
               end else if (wait_cnt_reg == CNT_MAX) begin
                  psel_reg           <= 1'b0;
                  penable_reg        <= 1'b0;
                  rsp_valid_reg      <= 1'b1;
                  rsp_rdata_reg      <= '0;
                  rsp_slverr_reg     <= 1'b0;
                  rsp_parity_err_reg <= 1'b0;
                  rsp_timeout_reg    <= 1'b1;
                  state_reg          <= S_RESP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg      <= 1'b0;
                  rsp_rdata_reg      <= '0;
                  rsp_slverr_reg     <= 1'b0;
                  rsp_parity_err_reg <= 1'b0;
                  rsp_timeout_reg    <= 1'b0;
                  cmd_ready_reg      <= 1'b1;
                  state_reg          <= S_IDLE;
               end
            end

            default: begin
               state_reg     <= S_IDLE;
               cmd_ready_reg <= 1'b1;
               psel_reg      <= 1'b0;
               penable_reg   <= 1'b0;
               rsp_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready      = cmd_ready_reg;
   assign rsp_valid      = rsp_valid_reg;
   assign rsp_rdata      = rsp_rdata_reg;
   assign rsp_slverr     = rsp_slverr_reg;
   assign rsp_parity_err = rsp_parity_err_reg;
   assign rsp_timeout    = rsp_timeout_reg;
   assign PSEL           = psel_reg;
   assign PENABLE        = penable_reg;
   assign PWRITE         = pwrite_reg;
   assign PADDR          = paddr_reg;
   assign PWDATA         = pwdata_reg;
   assign PSTRB          = pstrb_reg;
   assign PADDRCHK       = paddrchk_reg;
   assign PWDATACHK      = pwdatachk_reg;
   assign PSTRBCHK       = pstrbchk_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: hand-computed APB timing, parity, timeout and reset checks.
module tb_apb_master_bridge;

   logic        PCLK;
   logic        PRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_slverr;
   logic        rsp_parity_err;
   logic        rsp_timeout;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [3:0]  PADDRCHK;
   logic [3:0]  PWDATACHK;
   logic        PSTRBCHK;
   logic        PREADY;
   logic        PSLVERR;
   logic [31:0] PRDATA;
   logic [3:0]  PRDATACHK;

   int n_vec = 0;
   int n_err = 0;

   apb_master_bridge #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .STRB_WIDTH    (4),
      .PARITY_WIDTH  (4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_strb      (cmd_strb),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_slverr    (rsp_slverr),
      .rsp_parity_err(rsp_parity_err),
      .rsp_timeout   (rsp_timeout),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PWRITE        (PWRITE),
      .PADDR         (PADDR),
      .PWDATA        (PWDATA),
      .PSTRB         (PSTRB),
      .PADDRCHK      (PADDRCHK),
      .PWDATACHK     (PWDATACHK),
      .PSTRBCHK      (PSTRBCHK),
      .PREADY        (PREADY),
      .PSLVERR       (PSLVERR),
      .PRDATA        (PRDATA),
      .PRDATACHK     (PRDATACHK)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Advance one clock and settle just past the edge, where inputs change and outputs are sampled.
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_strb  = s;
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_rsp_valid_clr"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      int cnt;
      PRESETn   = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      rsp_ready = 1'b0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      PRDATA    = '0;
      PRDATACHK = '0;
      #2 PRESETn = 1'b0;
      tick();
      tick();

      // ---- reset state ----
      chk("rst_psel",      64'(PSEL), 64'd0);
      chk("rst_penable",   64'(PENABLE), 64'd0);
      chk("rst_pwrite",    64'(PWRITE), 64'd0);
      chk("rst_paddr",     64'(PADDR), 64'd0);
      chk("rst_pwdata",    64'(PWDATA), 64'd0);
      chk("rst_pstrb",     64'(PSTRB), 64'd0);
      chk("rst_paddrchk",  64'(PADDRCHK), 64'hF);
      chk("rst_pwdatachk", 64'(PWDATACHK), 64'hF);
      chk("rst_pstrbchk",  64'(PSTRBCHK), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_flags", 64'({rsp_slverr, rsp_parity_err, rsp_timeout}), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      PRESETn = 1'b1;
      tick();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      $display("txn reset: done");

      // ---- write, 2 wait states, PSLVERR high only while PREADY low ----
      set_cmd(1'b1, 32'h0009_0010, 32'hA5A5_00FF, 4'hF);
      tick();                                   // edge N: accepted, SETUP cycle N+1
      cmd_valid = 1'b0;
      chk("w1_setup_psel",    64'(PSEL), 64'd1);
      chk("w1_setup_penable", 64'(PENABLE), 64'd0);
      chk("w1_cmd_ready",     64'(cmd_ready), 64'd0);
      chk("w1_pwrite",        64'(PWRITE), 64'd1);
      chk("w1_paddr",         64'(PADDR), 64'h0009_0010);
      chk("w1_pwdata",        64'(PWDATA), 64'hA5A5_00FF);
      chk("w1_pstrb",         64'(PSTRB), 64'hF);
      chk("w1_paddrchk",      64'(PADDRCHK), 64'hE);
      chk("w1_pwdatachk",     64'(PWDATACHK), 64'hF);
      chk("w1_pstrbchk",      64'(PSTRBCHK), 64'd1);
      PSLVERR = 1'b1;
      tick();                                   // ACCESS cycle N+2
      chk("w1_acc1", 64'({PSEL, PENABLE, rsp_valid}), 64'b110);
      tick();                                   // ACCESS cycle N+3
      chk("w1_acc2", 64'({PSEL, PENABLE, rsp_valid}), 64'b110);
      tick();                                   // ACCESS cycle N+4
      chk("w1_acc3", 64'({PSEL, PENABLE, rsp_valid}), 64'b110);
      chk("w1_acc3_paddr_hold", 64'(PADDR), 64'h0009_0010);
      PREADY  = 1'b1;
      PSLVERR = 1'b0;
      tick();                                   // cycle N+5: response
      PREADY = 1'b0;
      chk("w1_rsp_valid",  64'({PSEL, PENABLE, rsp_valid}), 64'b001);
      chk("w1_rsp_slverr", 64'(rsp_slverr), 64'd0);
      chk("w1_rsp_rdata",  64'(rsp_rdata), 64'd0);
      chk("w1_rsp_flags",  64'({rsp_parity_err, rsp_timeout}), 64'd0);
      finish_rsp("w1");
      chk("w1_idle_paddr_retained", 64'(PADDR), 64'h0009_0010);
      $display("txn write 0x00090010 <= 0xA5A500FF, 2 waits: slverr=%0d", 0);

      // ---- read, zero wait, correct PRDATACHK ----
      set_cmd(1'b0, 32'h0000_0104, 32'h0, 4'hF);
      tick();
      cmd_valid = 1'b0;
      chk("r1_pwrite",   64'(PWRITE), 64'd0);
      chk("r1_pstrb",    64'(PSTRB), 64'd0);
      chk("r1_pstrbchk", 64'(PSTRBCHK), 64'd1);
      chk("r1_paddrchk", 64'(PADDRCHK), 64'hC);
      PREADY    = 1'b1;
      PRDATA    = 32'h0000_0001;
      PRDATACHK = 4'hE;
      tick();                                   // ACCESS cycle N+2
      chk("r1_access", 64'({PSEL, PENABLE, rsp_valid}), 64'b110);
      tick();                                   // cycle N+3
      PREADY = 1'b0;
      chk("r1_rsp_valid",  64'(rsp_valid), 64'd1);
      chk("r1_rsp_rdata",  64'(rsp_rdata), 64'h1);
      chk("r1_parity_err", 64'(rsp_parity_err), 64'd0);
      finish_rsp("r1");
      $display("txn read 0x00000104 => 0x00000001 chk=E");

      // ---- read, zero wait, wrong PRDATACHK ----
      set_cmd(1'b0, 32'h0000_0104, 32'h0, 4'h0);
      tick();
      cmd_valid = 1'b0;
      PREADY    = 1'b1;
      PRDATACHK = 4'hF;
      tick();
      tick();
      PREADY = 1'b0;
      chk("r2_rsp_valid",  64'(rsp_valid), 64'd1);
      chk("r2_rsp_rdata",  64'(rsp_rdata), 64'h1);
      chk("r2_parity_err", 64'(rsp_parity_err), 64'd1);
      finish_rsp("r2");
      $display("txn read 0x00000104 => 0x00000001 chk=F (parity error)");

      // ---- read timeout: PREADY held low ----
      set_cmd(1'b0, 32'h0000_0300, 32'h0, 4'h0);
      PRDATA    = 32'h1234_5678;
      PRDATACHK = 4'h0;
      tick();
      cmd_valid = 1'b0;
      tick();                                   // first ACCESS cycle N+2
      cnt = 0;
      while (!rsp_valid && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("to_cycles_to_rsp", 64'(cnt), 64'd16);
      chk("to_bus_dropped",   64'({PSEL, PENABLE}), 64'd0);
      chk("to_rsp_timeout",   64'(rsp_timeout), 64'd1);
      chk("to_rsp_rdata",     64'(rsp_rdata), 64'd0);
      finish_rsp("to");
      $display("txn read 0x00000300 timeout after %0d ACCESS cycles", cnt);

      // ---- PREADY arrives exactly in the 16th ACCESS cycle ----
      set_cmd(1'b0, 32'h0000_0304, 32'h0, 4'h0);
      tick();
      cmd_valid = 1'b0;
      tick();                                   // ACCESS cycle 1
      for (int i = 0; i < 15; i++) tick();      // ACCESS cycle 16
      chk("late_still_access", 64'({PSEL, PENABLE, rsp_valid}), 64'b110);
      PREADY    = 1'b1;
      PRDATA    = 32'hDEAD_BEEF;
      PRDATACHK = 4'hA;
      tick();
      PREADY = 1'b0;
      chk("late_rsp_valid",  64'(rsp_valid), 64'd1);
      chk("late_no_timeout", 64'(rsp_timeout), 64'd0);
      chk("late_rsp_rdata",  64'(rsp_rdata), 64'hDEAD_BEEF);
      chk("late_parity_ok",  64'(rsp_parity_err), 64'd0);
      finish_rsp("late");
      $display("txn read 0x00000304 => 0xDEADBEEF in last allowed ACCESS cycle");

      // ---- write with PSLVERR+PREADY, response back-pressured 5 cycles ----
      set_cmd(1'b1, 32'h0000_0020, 32'h0000_0001, 4'h1);
      tick();
      cmd_valid = 1'b0;
      chk("w2_pwdatachk", 64'(PWDATACHK), 64'hE);
      chk("w2_pstrbchk",  64'(PSTRBCHK), 64'd0);
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      tick();
      tick();
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      set_cmd(1'b0, 32'h0000_0200, 32'h0, 4'h0);  // pending while response stalls
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_hold", 64'({rsp_valid, rsp_slverr, rsp_timeout, rsp_parity_err}), 64'b1100);
         chk("bp_rsp_rdata", 64'(rsp_rdata), 64'd0);
         chk("bp_no_accept", 64'({cmd_ready, PSEL}), 64'd0);
         tick();
      end
      chk("bp_still_valid", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      tick();                                   // handshake, back to IDLE
      rsp_ready = 1'b0;
      chk("bp_idle", 64'({rsp_valid, cmd_ready, PSEL}), 64'b010);
      $display("txn write 0x00000020 <= 0x00000001 slverr=1, 5-cycle backpressure");
      tick();                                   // pending command accepted
      cmd_valid = 1'b0;
      chk("rr_setup_psel",  64'({PSEL, PENABLE}), 64'b10);
      chk("rr_setup_paddr", 64'(PADDR), 64'h0000_0200);

      // ---- reset in the middle of ACCESS ----
      tick();
      tick();
      chk("rr_in_access", 64'({PSEL, PENABLE}), 64'b11);
      PRESETn = 1'b0;
      #1;
      chk("rr_async_bus", 64'({PSEL, PENABLE}), 64'd0);
      chk("rr_async_paddr", 64'(PADDR), 64'd0);
      tick();
      PRESETn = 1'b1;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rsp_valid) cnt++;
      end
      chk("rr_no_rsp", 64'(cnt), 64'd0);
      chk("rr_cmd_ready", 64'(cmd_ready), 64'd1);
      $display("txn read 0x00000200 dropped by reset");

      // ---- normal command after reset ----
      set_cmd(1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF);
      tick();
      cmd_valid = 1'b0;
      PREADY = 1'b1;
      tick();
      chk("post_rst_access", 64'({PSEL, PENABLE, rsp_valid}), 64'b110);
      tick();
      PREADY = 1'b0;
      chk("post_rst_rsp", 64'({rsp_valid, rsp_slverr, rsp_timeout}), 64'b100);
      finish_rsp("post_rst");
      $display("txn write 0x00000040 <= 0x12345678 after reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
